// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative instruction cache with line fill and fence.i flush
//
// Purpose: WAYS-way, SETS-set instruction cache. Hits are answered in the same
// cycle. Misses fetch a whole line over cbus as one INCR burst. fence_i
// invalidates every line at one set per cycle.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   ireq       fetch request {valid, addr}
//   iresp      fetch response {addr_ok, data_ok, data[31:0]}
//   creq       line-fill burst request to memory
//   cresp      line-fill response {ready, last, data[63:0]}
//   fence_i    one-cycle pulse that invalidates the whole cache
//   flush_busy high while a flush is pending or running
// Optional feature (macro ICACHE_PERF_EN): adds the 32-bit counters hit_cnt and miss_cnt.

package icache_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  localparam logic [2:0] MSIZE8         = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
endpackage

module icache_assoc
  import icache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_BEATS = 16,
  parameter int ADDR_BITS  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  input  logic       fence_i,
  output logic       flush_busy
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(8 * LINE_BEATS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_BITS - OFF_W - IDX_W;
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_t;

  state_t             r_state;
  logic [BEAT_W-1:0]  r_beat;
  logic               r_pending;
  logic [IDX_W-1:0]   r_flush_idx;
  logic [IDX_W-1:0]   r_fill_idx;
  logic [WAY_W-1:0]   r_fill_way;
  logic [TAG_W-1:0]   r_fill_tag;
  logic [63:0]        r_fill_addr;
  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAY_W-1:0]   r_rr    [SETS];
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [63:0]        r_data  [SETS][WAYS][LINE_BEATS];

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [BEAT_W-1:0]  w_word;
  logic               w_hit;
  logic [WAY_W-1:0]   w_hit_way;
  logic               w_inv_found;
  logic [WAY_W-1:0]   w_inv_way;
  logic [WAY_W-1:0]   w_victim;
  logic [63:0]        w_word_data;
  logic               w_start_fill;
  logic               w_unused;

  assign w_idx  = ireq.addr[OFF_W +: IDX_W];
  assign w_tag  = ireq.addr[OFF_W + IDX_W +: TAG_W];
  assign w_word = ireq.addr[3 +: BEAT_W];

  // Tag compare across the set, plus lowest-index invalid way for victim choice.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = ireq.valid;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_idx][w] && !w_inv_found) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
  end

  assign w_victim     = w_inv_found ? w_inv_way : r_rr[w_idx];
  assign w_word_data  = r_data[w_idx][w_hit_way][w_word];
  // fence_i wins over a simultaneous miss; the miss is retried after the flush.
  assign w_start_fill = (r_state == S_IDLE) && ireq.valid && !w_hit && !fence_i;

  assign iresp.addr_ok = 1'b1;
  assign iresp.data_ok = (r_state == S_IDLE) && !r_pending && w_hit;
  assign iresp.data    = ireq.addr[2] ? w_word_data[63:32] : w_word_data[31:0];

  assign creq.valid    = (r_state == S_FETCH);
  assign creq.is_write = 1'b0;
  assign creq.size     = MSIZE8;
  assign creq.addr     = r_fill_addr;
  assign creq.strobe   = '0;
  assign creq.data     = '0;
  assign creq.len      = 8'(LINE_BEATS - 1);
  assign creq.burst    = AXI_BURST_INCR;

  assign flush_busy = r_pending || (r_state == S_FLUSH);

  generate
    if (ADDR_BITS < 64) begin : g_hi_unused
      assign w_unused = ^{ireq.addr[63:ADDR_BITS], ireq.addr[1:0]};
    end else begin : g_lo_unused
      assign w_unused = ^ireq.addr[1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_pending   <= 1'b0;
      r_flush_idx <= '0;
      r_fill_idx  <= '0;
      r_fill_way  <= '0;
      r_fill_tag  <= '0;
      r_fill_addr <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fence_i) begin
            r_state     <= S_FLUSH;
            r_flush_idx <= '0;
          end else if (w_start_fill) begin
            r_state     <= S_FETCH;
            r_beat      <= '0;
            r_fill_idx  <= w_idx;
            r_fill_way  <= w_victim;
            r_fill_tag  <= w_tag;
            r_fill_addr <= {ireq.addr[63:OFF_W], {OFF_W{1'b0}}};
          end
        end
        S_FETCH: begin
          if (fence_i) r_pending <= 1'b1;
          if (cresp.ready) begin
            r_beat <= r_beat + 1'b1;
            if (cresp.last) begin
              r_valid[r_fill_idx][r_fill_way] <= 1'b1;
              r_rr[r_fill_idx] <= (r_rr[r_fill_idx] == WAY_W'(WAYS - 1)) ? '0 : r_rr[r_fill_idx] + 1'b1;
              r_beat      <= '0;
              r_pending   <= 1'b0;
              r_flush_idx <= '0;
              r_state     <= (r_pending || fence_i) ? S_FLUSH : S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          r_valid[r_flush_idx] <= '0;
          if (r_flush_idx == IDX_W'(SETS - 1)) r_state <= S_IDLE;
          else r_flush_idx <= r_flush_idx + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity alone decides a hit.
  always_ff @(posedge clk) begin
    if ((r_state == S_FETCH) && cresp.ready) begin
      r_data[r_fill_idx][r_fill_way][r_beat] <= cresp.data;
      if (cresp.last) r_tag[r_fill_idx][r_fill_way] <= r_fill_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (iresp.data_ok) hit_cnt <= hit_cnt + 32'd1;
      if (w_start_fill) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - self-checking bench for icache_assoc against a line-level cache model
module tb_icache_assoc;
  import icache_pkg::*;

  localparam int WAYS = 2;
  localparam int SETS = 64;
  localparam int LB   = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       fence_i;
  logic       flush_busy;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_BEATS(LB), .ADDR_BITS(32)) dut (
    .clk(clk),
    .reset(rst_n),
    .ireq(ireq),
    .iresp(iresp),
    .creq(creq),
    .cresp(cresp),
    .fence_i(fence_i),
    .flush_busy(flush_busy)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: which line (address / 128) sits in each slot of each set.
  logic [31:0] m_line  [SETS][WAYS];
  bit          m_valid [SETS][WAYS];
  int          m_rr    [SETS];

  // Observations recorded by the driver.
  int          o_fills, o_first_creq, o_ok_cycle, o_last_cycle, o_busy_cycles;
  logic [31:0] o_data;
  bit          o_got, o_bad_field, o_ok_in_fetch, o_ok_in_busy, o_aborted;
  logic        o_creq_after_rst, o_busy_after_rst, o_ok_after_rst;

  function automatic logic [63:0] mem_word(input logic [63:0] line, input int beat);
    logic [31:0] hi, lo;
    hi = line[31:0] ^ 32'h5A5A_0000 ^ 32'(beat);
    lo = (line[31:0] + 32'(beat) * 32'd8) ^ 32'h0000_C3C3;
    return {hi, lo};
  endfunction

  function automatic logic [31:0] exp_data(input logic [63:0] a);
    logic [63:0] w;
    w = mem_word({a[63:7], 7'b0}, int'(a[6:3]));
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  function automatic int set_of(input logic [63:0] a);
    return int'((a[31:0] / 32'd128) % 32'(SETS));
  endfunction

  function automatic bit model_hit(input logic [63:0] a);
    int s;
    s = set_of(a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_line[s][w] == a[31:0] / 32'd128) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_fill(input logic [63:0] a);
    int s, v;
    s = set_of(a);
    v = -1;
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) v = m_rr[s];
    m_valid[s][v] = 1'b1;
    m_line[s][v]  = a[31:0] / 32'd128;
    m_rr[s]       = (m_rr[s] + 1) % WAYS;
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ireq = '0;
    cresp = '0;
    fence_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Presents one fetch, acts as memory for any fill, records what happened.
  task automatic do_fetch(input logic [63:0] a, input bit stall, input int fence_beat,
                          input int reset_beat, input bit fence_start);
    int beat;
    bit prev_cv, fenced;
    o_fills = 0; o_first_creq = -1; o_ok_cycle = -1; o_last_cycle = -1; o_busy_cycles = 0;
    o_data = '0; o_got = 0; o_bad_field = 0; o_ok_in_fetch = 0; o_ok_in_busy = 0; o_aborted = 0;
    beat = 0; prev_cv = 0; fenced = 0;
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = a;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      fence_i = (cyc == 0) && fence_start;
      cresp = '0;
      #1;
      if (flush_busy) o_busy_cycles++;
      if (creq.valid) begin
        if (!prev_cv) begin
          o_fills++;
          beat = 0;
          if (o_first_creq < 0) o_first_creq = cyc;
        end
        if (creq.is_write !== 1'b0 || creq.size !== MSIZE8 || creq.len !== 8'(LB - 1) ||
            creq.burst !== AXI_BURST_INCR || creq.strobe !== 8'h0 || creq.data !== 64'h0 ||
            creq.addr !== {a[63:7], 7'b0}) o_bad_field = 1;
        if (iresp.data_ok) o_ok_in_fetch = 1;
        if (reset_beat >= 0 && beat == reset_beat) begin
          rst_n = 1'b0;
          #1;
          o_creq_after_rst = creq.valid;
          o_busy_after_rst = flush_busy;
          o_ok_after_rst   = iresp.data_ok;
          o_aborted = 1;
          ireq.valid = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (fence_beat >= 0 && beat == fence_beat && !fenced) begin
          fence_i = 1'b1;
          fenced = 1;
        end
        if (!stall || $urandom_range(3) != 0) begin
          cresp.ready = 1'b1;
          cresp.last  = (beat == LB - 1);
          cresp.data  = mem_word(creq.addr, beat);
          if (beat == LB - 1) o_last_cycle = cyc;
          beat++;
        end
      end
      prev_cv = creq.valid;
      if (iresp.data_ok) begin
        if (flush_busy) o_ok_in_busy = 1;
        o_got = 1;
        o_ok_cycle = cyc;
        o_data = iresp.data;
        @(posedge clk);
        #1;
        ireq.valid = 1'b0;
        fence_i = 1'b0;
        cresp = '0;
        return;
      end
      @(negedge clk);
    end
    ireq.valid = 1'b0;
    fence_i = 1'b0;
    cresp = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ireq.valid = 1'b1;
    ireq.addr = 64'h8000_0004;
    cresp = '0;
    fence_i = 1'b0;
    #1;
    checks++; if (iresp.data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got %b need 0", iresp.data_ok); end
    checks++; if (creq.valid !== 1'b0) begin errors++; $display("FAIL reset_creq_valid: got %b need 0", creq.valid); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_flush_busy: got %b need 0", flush_busy); end
    checks++; if (iresp.addr_ok !== 1'b1) begin errors++; $display("FAIL reset_addr_ok: got %b need 1", iresp.addr_ok); end
    @(negedge clk);
    ireq.valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (creq.valid !== 1'b0 || flush_busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got creq=%b busy=%b need 0 0", creq.valid, flush_busy); end
    model_reset();
  endtask

  task automatic test_cold_miss();
    logic [63:0] a;
    apply_reset();
    a = 64'h8000_0004;
    do_fetch(a, 1'b0, -1, -1, 1'b0);
    checks++; if (o_fills !== 1) begin errors++; $display("FAIL cold_fills: got %0d need 1", o_fills); end
    checks++; if (o_first_creq !== 1) begin errors++; $display("FAIL cold_creq_cycle: got %0d need 1", o_first_creq); end
    checks++; if (o_bad_field !== 1'b0) begin errors++; $display("FAIL cold_creq_fields: got bad=%b need 0", o_bad_field); end
    checks++; if (o_ok_in_fetch !== 1'b0) begin errors++; $display("FAIL cold_ok_in_fetch: got %b need 0", o_ok_in_fetch); end
    checks++; if (o_ok_cycle !== o_last_cycle + 1 || o_last_cycle !== 16) begin errors++; $display("FAIL cold_latency: got ok=%0d last=%0d need 17 16", o_ok_cycle, o_last_cycle); end
    checks++; if (o_data !== exp_data(a)) begin errors++; $display("FAIL cold_data: got %h need %h", o_data, exp_data(a)); end
    model_fill(a);
    foreach (a[i]) ;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 64'h8000_0000 : (k == 1) ? 64'h8000_0078 : 64'h8000_003C;
      do_fetch(a, 1'b0, -1, -1, 1'b0);
      checks++; if (o_fills !== 0 || o_ok_cycle !== 0) begin errors++; $display("FAIL hit_%0d: got fills=%0d ok_cycle=%0d need 0 0", k, o_fills, o_ok_cycle); end
      checks++; if (o_data !== exp_data(a)) begin errors++; $display("FAIL hit_data_%0d: got %h need %h", k, o_data, exp_data(a)); end
    end
  endtask

  task automatic test_conflict();
    logic [63:0] seq [7];
    int exp_f;
    seq = '{64'h8000_0000, 64'h8000_2000, 64'h8000_4000, 64'h8000_2000,
            64'h8000_4004, 64'h8000_0000, 64'h8000_2008};
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      exp_f = model_hit(seq[k]) ? 0 : 1;
      do_fetch(seq[k], 1'b0, -1, -1, 1'b0);
      checks++; if (o_fills !== exp_f || o_got !== 1'b1) begin errors++; $display("FAIL conflict_%0d: got fills=%0d got=%b need %0d 1", k, o_fills, o_got, exp_f); end
      checks++; if (o_data !== exp_data(seq[k])) begin errors++; $display("FAIL conflict_data_%0d: got %h need %h", k, o_data, exp_data(seq[k])); end
      if (exp_f == 1) model_fill(seq[k]);
    end
  endtask

  task automatic test_flush();
    int busy;
    apply_reset();
    do_fetch(64'h8000_0000, 1'b0, -1, -1, 1'b0);
    model_fill(64'h8000_0000);
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      fence_i = (i == 0) || (i == 10);
      #1;
      if (flush_busy) busy++;
      if (i > 12 && !flush_busy) break;
    end
    fence_i = 1'b0;
    model_clear();
    checks++; if (busy !== SETS) begin errors++; $display("FAIL flush_duration: got %0d need %0d", busy, SETS); end
    do_fetch(64'h8000_0000, 1'b0, -1, -1, 1'b0);
    checks++; if (o_fills !== 1) begin errors++; $display("FAIL flush_refetch_miss: got fills=%0d need 1", o_fills); end
    model_fill(64'h8000_0000);
  endtask

  task automatic test_flush_during_fill();
    logic [63:0] a;
    apply_reset();
    a = 64'h8000_0104;
    do_fetch(a, 1'b0, 5, -1, 1'b0);
    checks++; if (o_fills !== 2) begin errors++; $display("FAIL fdf_fills: got %0d need 2", o_fills); end
    checks++; if (o_ok_in_busy !== 1'b0 || o_ok_in_fetch !== 1'b0) begin errors++; $display("FAIL fdf_early_ok: got busy=%b fetch=%b need 0 0", o_ok_in_busy, o_ok_in_fetch); end
    checks++; if (o_busy_cycles !== 10 + SETS) begin errors++; $display("FAIL fdf_busy_cycles: got %0d need %0d", o_busy_cycles, 10 + SETS); end
    checks++; if (o_got !== 1'b1 || o_data !== exp_data(a)) begin errors++; $display("FAIL fdf_data: got %h need %h", o_data, exp_data(a)); end
    model_fill(a);
  endtask

  task automatic test_fence_with_miss();
    logic [63:0] a;
    apply_reset();
    a = 64'h8000_0200;
    do_fetch(a, 1'b0, -1, -1, 1'b1);
    checks++; if (o_first_creq !== SETS + 2) begin errors++; $display("FAIL fence_miss_order: got creq at %0d need %0d", o_first_creq, SETS + 2); end
    checks++; if (o_busy_cycles !== SETS || o_fills !== 1) begin errors++; $display("FAIL fence_miss_flush: got busy=%0d fills=%0d need %0d 1", o_busy_cycles, o_fills, SETS); end
    checks++; if (o_data !== exp_data(a)) begin errors++; $display("FAIL fence_miss_data: got %h need %h", o_data, exp_data(a)); end
    model_fill(a);
  endtask

  task automatic test_reset_mid_fill();
    apply_reset();
    do_fetch(64'h8000_0300, 1'b0, -1, -1, 1'b0);
    do_fetch(64'h8000_0380, 1'b0, -1, 8, 1'b0);
    checks++; if (o_aborted !== 1'b1 || o_creq_after_rst !== 1'b0) begin errors++; $display("FAIL rst_fill_creq_drop: got aborted=%b creq=%b need 1 0", o_aborted, o_creq_after_rst); end
    checks++; if (o_busy_after_rst !== 1'b0 || o_ok_after_rst !== 1'b0) begin errors++; $display("FAIL rst_fill_outputs: got busy=%b ok=%b need 0 0", o_busy_after_rst, o_ok_after_rst); end
    model_reset();
    do_fetch(64'h8000_0380, 1'b0, -1, -1, 1'b0);
    checks++; if (o_fills !== 1 || o_data !== exp_data(64'h8000_0380)) begin errors++; $display("FAIL rst_fill_refetch: got fills=%0d data=%h need 1 %h", o_fills, o_data, exp_data(64'h8000_0380)); end
    model_fill(64'h8000_0380);
    do_fetch(64'h8000_0300, 1'b0, -1, -1, 1'b0);
    checks++; if (o_fills !== 1) begin errors++; $display("FAIL rst_clears_valid: got fills=%0d need 1", o_fills); end
    model_fill(64'h8000_0300);
  endtask

  task automatic test_random();
    logic [63:0] a;
    int exp_f, busy_wait;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(7) == 0) begin
        @(negedge clk);
        fence_i = 1'b1;
        @(negedge clk);
        fence_i = 1'b0;
        busy_wait = 0;
        while (flush_busy && busy_wait < 500) begin @(negedge clk); busy_wait++; end
        checks++; if (busy_wait >= 500) begin errors++; $display("FAIL rand_flush_timeout: got %0d need <500", busy_wait); end
        model_clear();
      end
      a = 64'h1000_0000 + 64'($urandom_range(3)) * 64'h2000 + 64'($urandom_range(1)) * 64'h80
          + 64'($urandom_range(31)) * 64'd4;
      exp_f = model_hit(a) ? 0 : 1;
      do_fetch(a, 1'b1, -1, -1, 1'b0);
      checks++; if (o_fills !== exp_f || o_got !== 1'b1 || o_ok_in_fetch !== 1'b0) begin errors++; $display("FAIL rand_fill_%0d: addr %h got fills=%0d got=%b need %0d 1", n, a, o_fills, o_got, exp_f); end
      checks++; if (o_data !== exp_data(a)) begin errors++; $display("FAIL rand_data_%0d: addr %h got %h need %h", n, a, o_data, exp_data(a)); end
      if (exp_f == 1) begin
        checks++; if (o_ok_cycle !== o_last_cycle + 1) begin errors++; $display("FAIL rand_latency_%0d: got ok=%0d last=%0d need last+1", n, o_ok_cycle, o_last_cycle); end
        model_fill(a);
      end
    end
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf();
    apply_reset();
    #1;
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset: got hit=%0d miss=%0d need 0 0", hit_cnt, miss_cnt); end
    for (int k = 0; k < 4; k++) do_fetch(64'h8000_0400 + 64'(k) * 64'd8, 1'b0, -1, -1, 1'b0);
    @(negedge clk);
    checks++; if (miss_cnt !== 32'd1) begin errors++; $display("FAIL perf_miss: got %0d need 1", miss_cnt); end
    checks++; if (hit_cnt !== 32'd4) begin errors++; $display("FAIL perf_hit: got %0d need 4", hit_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    ireq = '0;
    cresp = '0;
    fence_i = 1'b0;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_flush();
    test_flush_during_fill();
    test_fence_with_miss();
    test_reset_mid_fill();
    test_random();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
